psum_accumulator: RTL and testbench
===================================

Name: psum_accumulator

Overview:
- Producer side of the ReLU activation interface: accumulates a configurable number of signed partial products (one conv window / channel group) into one signed result, requantizes, saturates and presents it to RELU.input_relu.
- Sits between the MAC array and RELU.
- Valid/ready on both sides; one result per window.

Parameters:
- IN_WIDTH, 16, width of signed partial-product input.
- OUT_WIDTH, 20, width of signed result; matches RELU INPUT_WIDTH.
- ACC_WIDTH, 24, internal accumulator width; must be >= IN_WIDTH+$clog2(MAX_TERMS) (elaboration-time $error otherwise).
- MAX_TERMS, 9, maximum terms per window (3x3 kernel).
- OUT_SHIFT, 0, arithmetic right shift applied before saturation (0..ACC_WIDTH-1).

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset.
- num_terms, input, $clog2(MAX_TERMS+1), terms in next window; sampled on the first accepted beat.
- in_valid, input, 1, partial product valid.
- in_ready, output, 1, block can accept a beat.
- in_data, input, IN_WIDTH signed, partial product.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts result.
- out_data, output, OUT_WIDTH signed, saturated result to RELU.
- out_sat, output, 1, out_data was clamped.
- busy, output, 1, window in progress or result held.

Interface decision (already decided): one clock `clk`; reset `rst` is synchronous and active-high.

Behaviour:
- Reset state (rst=1 at posedge):
  - state=IDLE, accumulator=0, count=0.
  - out_valid=0, out_data=0, out_sat=0, busy=0.
  - in_ready=1 from the next cycle.
- Reset mid-window or during HOLD: the partial or held result is discarded with no output; takes priority over all other events.
- Beat acceptance: a beat transfers when in_valid && in_ready at posedge. An output transfers when out_valid && out_ready.
- num_terms mapping: 0 is treated as 1; values > MAX_TERMS are clamped to MAX_TERMS. The mapped value is latched as target.
- FSM IDLE:
  - in_ready=1, busy=0.
  - On accept: acc=sext(in_data), count=1, latch target.
  - target==1 -> HOLD; else -> ACCUM.
- FSM ACCUM:
  - in_ready=1, busy=1.
  - Each accepted beat: acc+=sext(in_data), count++.
  - The beat that makes count==target -> HOLD.
  - in_valid gaps (bubbles) are allowed and do not advance count.
- FSM HOLD:
  - in_ready=0, busy=1.
  - out_valid=1; out_data and out_sat are registered and stable while out_valid && !out_ready.
  - On out_ready -> IDLE.
  - in_ready is registered state only; no combinational out_ready->in_ready path.
- Latency: out_valid rises the cycle after the last beat is accepted.
- Throughput: target+1 cycles per window minimum.
- Requantize:
  - r = acc >>> OUT_SHIFT, with round-half-up when OUT_SHIFT>0: add 1<<(OUT_SHIFT-1) before the shift.
  - The rounding add is performed in ACC_WIDTH+1 bits.
- Saturate:
  - if r > 2^(OUT_WIDTH-1)-1 -> out_data=max, out_sat=1.
  - if r < -2^(OUT_WIDTH-1) -> out_data=min, out_sat=1.
  - otherwise out_data=r, out_sat=0.
  - Computed on the HOLD entry edge.
- X-handling: in_data is ignored when in_valid=0. Accumulator state never latches X from a non-accepted beat.

Optional Feature:
- Macro: PSUM_ACCUMULATOR_BIAS_EN.
- Defined:
  - Adds input port bias_in, width OUT_WIDTH, signed, sampled with the first beat.
  - Accumulator initial value = sext(bias_in << OUT_SHIFT) + sext(in_data).
  - ACC_WIDTH check gains +1 bit.
- Undefined:
  - Port absent; initial value = sext(in_data).
  - Identical cycle behaviour either way.

Decomposition:
- Package psum_pkg:
  - typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} psum_state_t.
  - function sat_shift(acc, shift) for rounding, shift and clamp; returns {sat, value}.
  - Default width constants: IN=16, OUT=20, ACC=24, MAX_TERMS=9.
- Sub-module: psum_saturate, combinational round/shift/clamp, instantiated once.
- The FSM and accumulator stay in the top module.

Test Plan:
- Basic window: num_terms=3, beats 100, -50, 7 back-to-back -> out_valid one cycle after 3rd beat; out_data=57; out_sat=0; in_ready=0 until out_ready.
- Bubbles and backpressure: num_terms=4, beats 1, 2, 3, 4 with one idle cycle between each; out_ready=0 for 5 cycles -> out_data=10 held stable, in_ready=0, extra in_valid beats ignored; out_ready=1 -> IDLE next cycle.
- Saturation: instance with OUT_WIDTH=18, num_terms=9, all beats 32767 -> out_data=131071, out_sat=1. Repeat with all beats -32768 -> out_data=-131072, out_sat=1.
- Shift/round: OUT_SHIFT=2, num_terms=2, beats 5, 1 -> acc=6, out_data=2 (6+2=8, 8>>>2=2). Beats -5, -2 -> acc=-7, out_data=-2 (-7+2=-5, -5>>>2=-2).
- Boundary counts: num_terms=0 with beat -5 -> treated as 1, out_data=-5. num_terms=15 -> clamped to 9 beats.
- Reset mid-operation: rst=1 for 2 cycles after 2 of 3 beats -> out_valid never rises, out_data=0. Following window num_terms=2, beats 3, 4 -> out_data=7 (no residue).

Source files
------------

// File: rtl/psum_pkg.sv
// Shared types and helpers for the partial-sum accumulator.
// Holds the FSM state encoding, the default widths, and the
// round / shift / clamp function used by psum_saturate.
package psum_pkg;

  localparam int PSUM_IN_W      = 16;
  localparam int PSUM_OUT_W     = 20;
  localparam int PSUM_ACC_W     = 24;
  localparam int PSUM_MAX_TERMS = 9;

  // Fixed internal width of sat_shift. Any ACC_WIDTH up to 62 fits here
  // with headroom, so the rounding add cannot overflow. That gives the
  // same result as doing the add in ACC_WIDTH+1 bits.
  localparam int SAT_CALC_W = 64;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} psum_state_t;

  // Round half up, arithmetic shift right, then clamp to a signed
  // out_width range. The result is {sat, value}, and value is already
  // inside the out_width range.
  function automatic logic [SAT_CALC_W:0] sat_shift(
    input logic signed [SAT_CALC_W-1:0] acc,
    input int                           shift,
    input int                           out_width
  );
    logic signed [SAT_CALC_W-1:0] r;
    logic signed [SAT_CALC_W-1:0] max_v;
    logic signed [SAT_CALC_W-1:0] min_v;
    logic                         sat;
    r = acc;
    if (shift > 0) begin
      r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    end
    max_v = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (out_width - 1));
    sat   = 1'b0;
    if (r > max_v) begin
      r   = max_v;
      sat = 1'b1;
    end else if (r < min_v) begin
      r   = min_v;
      sat = 1'b1;
    end
    return {sat, r};
  endfunction

endpackage

// File: rtl/psum_saturate.sv
// Combinational requantizer. It rounds the accumulator half up, shifts it
// right by OUT_SHIFT, and saturates the result to OUT_WIDTH signed bits.
module psum_saturate
  import psum_pkg::*;
#(
  parameter int ACC_WIDTH = PSUM_ACC_W,
  parameter int OUT_WIDTH = PSUM_OUT_W,
  parameter int OUT_SHIFT = 0
) (
  input  logic signed [ACC_WIDTH-1:0] i_acc,
  output logic signed [OUT_WIDTH-1:0] o_data,
  output logic                        o_sat
);

  if (ACC_WIDTH > SAT_CALC_W - 2) begin : g_acc_w_chk
    $error("psum_saturate: ACC_WIDTH too large for sat_shift");
  end
  if (OUT_WIDTH >= SAT_CALC_W) begin : g_out_w_chk
    $error("psum_saturate: OUT_WIDTH too large for sat_shift");
  end

  logic signed [SAT_CALC_W-1:0] w_acc_ext;
  logic        [SAT_CALC_W:0]   w_res;
  logic                         w_unused_hi;

  assign w_acc_ext = SAT_CALC_W'(i_acc);

  // Round, shift and clamp in the package helper.
  always_comb begin
    w_res = sat_shift(w_acc_ext, OUT_SHIFT, OUT_WIDTH);
  end

  assign o_data      = w_res[OUT_WIDTH-1:0];
  assign o_sat       = w_res[SAT_CALC_W];
  // The upper bits are only sign copies once the value is clamped.
  assign w_unused_hi = ^w_res[SAT_CALC_W-1:OUT_WIDTH];

endmodule

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator that feeds RELU. It sums num_terms signed
// partial products into one window result, requantizes and saturates it,
// and holds the result on a valid/ready output until the consumer takes it.
// Optional macro PSUM_ACCUMULATOR_BIAS_EN adds a bias_in port. The bias is
// pre-shifted by OUT_SHIFT and loaded with the first beat of each window.
module psum_accumulator
  import psum_pkg::*;
#(
  parameter int IN_WIDTH  = PSUM_IN_W,
  parameter int OUT_WIDTH = PSUM_OUT_W,
  parameter int ACC_WIDTH = PSUM_ACC_W,
  parameter int MAX_TERMS = PSUM_MAX_TERMS,
  parameter int OUT_SHIFT = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [$clog2(MAX_TERMS+1)-1:0]     num_terms,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic signed [IN_WIDTH-1:0]         in_data,
`ifdef PSUM_ACCUMULATOR_BIAS_EN
  input  logic signed [OUT_WIDTH-1:0]        bias_in,
`endif
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic signed [OUT_WIDTH-1:0]        out_data,
  output logic                               out_sat,
  output logic                               busy
);

  localparam int CNT_W = $clog2(MAX_TERMS + 1);
`ifdef PSUM_ACCUMULATOR_BIAS_EN
  localparam int BIAS_BITS = 1;
`else
  localparam int BIAS_BITS = 0;
`endif
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_TERMS);

  if (ACC_WIDTH < IN_WIDTH + $clog2(MAX_TERMS) + BIAS_BITS) begin : g_acc_chk
    $error("psum_accumulator: ACC_WIDTH too narrow for IN_WIDTH and MAX_TERMS");
  end
  if (OUT_SHIFT < 0 || OUT_SHIFT >= ACC_WIDTH) begin : g_shift_chk
    $error("psum_accumulator: OUT_SHIFT out of range");
  end

  psum_state_t                  r_state;
  psum_state_t                  w_next_state;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic signed [ACC_WIDTH-1:0]  w_acc_next;
  logic signed [ACC_WIDTH-1:0]  w_in_ext;
  logic signed [ACC_WIDTH-1:0]  w_acc_first;
  logic [CNT_W-1:0]             r_count;
  logic [CNT_W-1:0]             r_target;
  logic [CNT_W-1:0]             w_target_map;
  logic                         w_in_open;
  logic                         w_accept;
  logic                         w_last;
  logic signed [OUT_WIDTH-1:0]  r_out_data;
  logic                         r_out_sat;
  logic signed [OUT_WIDTH-1:0]  w_sat_data;
  logic                         w_sat_flag;

  // in_ready is decoded from the state register only. It never depends on out_ready.
  assign w_in_open = (r_state == S_IDLE) || (r_state == S_ACCUM);
  assign in_ready  = w_in_open;
  assign w_accept  = in_valid && w_in_open;
  assign w_in_ext  = ACC_WIDTH'(in_data);

`ifdef PSUM_ACCUMULATOR_BIAS_EN
  assign w_acc_first = (ACC_WIDTH'(bias_in) <<< OUT_SHIFT) + w_in_ext;
`else
  assign w_acc_first = w_in_ext;
`endif

  // Map num_terms so that 0 becomes 1 and values above MAX_TERMS are clamped.
  always_comb begin
    w_target_map = num_terms;
    if (num_terms == '0) begin
      w_target_map = C_ONE;
    end else if (num_terms > C_MAX) begin
      w_target_map = C_MAX;
    end
  end

  // Next-state decode, status outputs and the accumulator's next value.
  always_comb begin
    // NOTE: every output gets a default first. Without it some case path
    // would leave a signal unassigned and synthesis would infer a latch.
    w_next_state = r_state;
    w_acc_next   = r_acc + w_in_ext;
    w_last       = 1'b0;
    busy         = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_acc_next = w_acc_first;
        if (w_accept) begin
          w_last       = (w_target_map == C_ONE);
          w_next_state = w_last ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        busy = 1'b1;
        if (w_accept) begin
          w_last = ((r_count + C_ONE) == r_target);
          if (w_last) begin
            w_next_state = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. All registers
    // then update together on the edge, whatever order the blocks run in.
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  psum_saturate #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_sat (
    .i_acc  (w_acc_next),
    .o_data (w_sat_data),
    .o_sat  (w_sat_flag)
  );

  // Accumulate accepted beats only. The result is captured on the edge that enters HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_count    <= '0;
      r_target   <= '0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
    end else if (w_accept) begin
      r_acc   <= w_acc_next;
      r_count <= (r_state == S_IDLE) ? C_ONE : r_count + C_ONE;
      if (r_state == S_IDLE) begin
        r_target <= w_target_map;
      end
      if (w_last) begin
        r_out_data <= w_sat_data;
        r_out_sat  <= w_sat_flag;
      end
    end
  end

  assign out_data = r_out_data;
  assign out_sat  = r_out_sat;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed testbench for psum_accumulator. Three instances share one
// stimulus stream: the default build, an 18-bit output variant, and a
// variant with OUT_SHIFT=2.
module tb_psum_accumulator;

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         num_terms;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               out_ready;

  logic               a_in_ready, a_out_valid, a_out_sat, a_busy;
  logic signed [19:0] a_out_data;
  logic               b_in_ready, b_out_valid, b_out_sat, b_busy;
  logic signed [17:0] b_out_data;
  logic               c_in_ready, c_out_valid, c_out_sat, c_busy;
  logic signed [19:0] c_out_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  psum_accumulator #(.OUT_SHIFT(0)) u_dut_a (
    .clk(clk), .rst(rst), .num_terms(num_terms), .in_valid(in_valid),
    .in_ready(a_in_ready), .in_data(in_data),
`ifdef PSUM_ACCUMULATOR_BIAS_EN
    .bias_in('0),
`endif
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_sat(a_out_sat), .busy(a_busy)
  );

  psum_accumulator #(.OUT_WIDTH(18)) u_dut_b (
    .clk(clk), .rst(rst), .num_terms(num_terms), .in_valid(in_valid),
    .in_ready(b_in_ready), .in_data(in_data),
`ifdef PSUM_ACCUMULATOR_BIAS_EN
    .bias_in('0),
`endif
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_sat(b_out_sat), .busy(b_busy)
  );

  psum_accumulator #(.OUT_SHIFT(2)) u_dut_c (
    .clk(clk), .rst(rst), .num_terms(num_terms), .in_valid(in_valid),
    .in_ready(c_in_ready), .in_data(in_data),
`ifdef PSUM_ACCUMULATOR_BIAS_EN
    .bias_in('0),
`endif
    .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
    .out_sat(c_out_sat), .busy(c_busy)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one beat for a single cycle. It is accepted on the next edge.
  task automatic beat(input int v);
    in_valid = 1'b1;
    in_data  = 16'(v);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    num_terms = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_data",  a_out_data,  0);
    check("rst_out_sat",   a_out_sat,   0);
    check("rst_busy",      a_busy,      0);
    check("rst_in_ready",  a_in_ready,  1);

    // Basic window. num_terms changes after the first beat and must be ignored.
    num_terms = 4'd3;
    beat(100);
    check("basic_nv1", a_out_valid, 0);
    num_terms = 4'd0;
    beat(-50);
    check("basic_nv2", a_out_valid, 0);
    beat(7);
    check("basic_valid",    a_out_valid, 1);
    check("basic_data",     a_out_data,  57);
    check("basic_sat",      a_out_sat,   0);
    check("basic_in_ready", a_in_ready,  0);
    check("basic_busy",     a_busy,      1);
    tick();
    check("basic_hold", a_out_data, 57);
    release_out();
    check("basic_done_valid", a_out_valid, 0);
    check("basic_done_ready", a_in_ready,  1);
    check("basic_done_busy",  a_busy,      0);

    // Bubbles between beats, then backpressure with stray in_valid beats.
    num_terms = 4'd4;
    for (int v = 1; v <= 4; v++) begin
      beat(v);
      if (v == 1) begin
        check("bub_busy",     a_busy,     1);
        check("bub_in_ready", a_in_ready, 1);
      end
      tick();
    end
    check("bub_valid", a_out_valid, 1);
    check("bub_data",  a_out_data,  10);
    in_valid = 1'b1;
    in_data  = 16'sd999;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_data",     a_out_data,  10);
      check("bp_valid",    a_out_valid, 1);
      check("bp_in_ready", a_in_ready,  0);
    end
    in_valid = 1'b0;
    release_out();
    check("bp_done_valid", a_out_valid, 0);
    check("bp_done_busy",  a_busy,      0);

    // Positive saturation: 9 * 32767 = 294903
    num_terms = 4'd9;
    for (int i = 0; i < 9; i++) beat(32767);
    check("satp_b_data", b_out_data, 131071);
    check("satp_b_sat",  b_out_sat,  1);
    check("satp_a_data", a_out_data, 294903);
    check("satp_a_sat",  a_out_sat,  0);
    check("satp_c_data", c_out_data, 73726);
    release_out();

    // Negative saturation: 9 * -32768 = -294912
    for (int i = 0; i < 9; i++) beat(-32768);
    check("satn_b_data", b_out_data, -131072);
    check("satn_b_sat",  b_out_sat,  1);
    check("satn_a_data", a_out_data, -294912);
    check("satn_c_data", c_out_data, -73728);
    check("satn_c_sat",  c_out_sat,  0);
    release_out();

    // Shift and round-half-up
    num_terms = 4'd2;
    beat(5);
    beat(1);
    check("rnd_pos_c", c_out_data, 2);
    check("rnd_pos_a", a_out_data, 6);
    release_out();
    beat(-5);
    beat(-2);
    check("rnd_neg_c", c_out_data, -2);
    check("rnd_neg_a", a_out_data, -7);
    release_out();

    // num_terms = 0 is treated as 1
    num_terms = 4'd0;
    beat(-5);
    check("nt0_valid", a_out_valid, 1);
    check("nt0_data",  a_out_data,  -5);
    check("nt0_c",     c_out_data,  -1);
    release_out();

    // num_terms = 15 is clamped to 9
    num_terms = 4'd15;
    for (int i = 0; i < 8; i++) beat(1);
    check("nt15_nv8",   a_out_valid, 0);
    beat(1);
    check("nt15_valid", a_out_valid, 1);
    check("nt15_data",  a_out_data,  9);
    release_out();

    // Reset in the middle of a window
    num_terms = 4'd3;
    beat(10);
    beat(20);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("mrst_busy",     a_busy,     0);
    check("mrst_in_ready", a_in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mrst_nv", a_out_valid, 0);
    end
    check("mrst_data", a_out_data, 0);
    num_terms = 4'd2;
    beat(3);
    beat(4);
    check("post_rst_valid", a_out_valid, 1);
    check("post_rst_data",  a_out_data,  7);
    release_out();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
